// File: rtl/matrix_skew_feeder.sv
// Skews K operand vectors onto N systolic-array edge lanes; lane i lags acceptance by i+1 cycles.
// Define MATRIX_FEED_LANE_VALID_EN to add the per-lane Lane_Valid output.
module matrix_skew_feeder #(
  parameter int N = 4,
  parameter int W = 32,
  parameter int K = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic           In_Valid,
  input  logic [N*W-1:0] In_Data,
  output logic           In_Ready,
  output logic [N*W-1:0] Feed_Data,
  output logic           PE_Clear,
  output logic           Busy,
  output logic           Done
`ifdef MATRIX_FEED_LANE_VALID_EN
  ,
  output logic [N-1:0]   Lane_Valid
`endif
);

  // state  | meaning
  // IDLE   | waiting for Start; lanes shift zeros
  // STREAM | In_Ready high, accepting K vectors (bubbles shift zeros)
  // DRAIN  | shifting zeros for 2N-1 cycles until the last product reaches PE(N-1,N-1)
  // DONE   | one-cycle Done pulse
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  localparam int ACC_W = (K > 1) ? $clog2(K) : 1;
  localparam int DR_W  = $clog2(2 * N);
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(K - 1);
  localparam logic [DR_W-1:0]  DR_LOAD  = DR_W'(2 * N - 2);

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc_cnt;
  logic [DR_W-1:0]   drain_cnt;
  logic              start_go;
  logic              accept;
  logic              last_accept;

  assign start_go    = (state == IDLE) && Start;
  assign accept      = In_Valid && In_Ready;
  assign last_accept = accept && (acc_cnt == ACC_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    In_Ready  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = STREAM;
      end
      STREAM: begin
        In_Ready = 1'b1;
        Busy     = 1'b1;
        if (In_Valid && (acc_cnt == ACC_LAST)) state_nxt = DRAIN;
      end
      DRAIN: begin
        Busy = 1'b1;
        if (drain_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accept counter counts up to K-1; drain timer is a down-counter loaded on the last accept.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_cnt   <= '0;
      drain_cnt <= '0;
      PE_Clear  <= 1'b0;
    end else begin
      PE_Clear <= start_go;
      if (start_go || last_accept) begin
        acc_cnt <= '0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + ACC_W'(1);
      end
      if (start_go) begin
        drain_cnt <= '0;
      end else if (last_accept) begin
        drain_cnt <= DR_LOAD;
      end else if ((state == DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DR_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0] chain [i+1];

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        for (int j = 0; j <= i; j++) chain[j] <= '0;
      end else if (start_go) begin
        for (int j = 0; j <= i; j++) chain[j] <= '0;
      end else begin
        chain[0] <= accept ? In_Data[i*W +: W] : '0;
        for (int j = 1; j <= i; j++) chain[j] <= chain[j-1];
      end
    end

    assign Feed_Data[i*W +: W] = chain[i];

`ifdef MATRIX_FEED_LANE_VALID_EN
    logic [i:0] vld;

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        vld <= '0;
      end else if (start_go) begin
        vld <= '0;
      end else begin
        vld[0] <= accept;
        for (int j = 1; j <= i; j++) vld[j] <= vld[j-1];
      end
    end

    assign Lane_Valid[i] = vld[i];
`endif
  end

endmodule
